// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP32 multiplier arbiter slice.
package fp_mult_pkg;

  typedef enum logic [1:0] {
    RND_NEAREST_EVEN = 2'd0,
    RND_TO_ZERO      = 2'd1,
    RND_UP           = 2'd2,
    RND_DOWN         = 2'd3
  } round_values;

  // Bit positions inside the 6-bit {zero, inf, nan, tiny, huge, inexact} flag word
  localparam int unsigned FLG_ZERO    = 5;
  localparam int unsigned FLG_INF     = 4;
  localparam int unsigned FLG_NAN     = 3;
  localparam int unsigned FLG_TINY    = 2;
  localparam int unsigned FLG_HUGE    = 1;
  localparam int unsigned FLG_INEXACT = 0;
  localparam int unsigned FLG_W       = 6;

  // Tag id is sized for the largest supported requester count (8)
  localparam int unsigned TAG_IDW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } fsm_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward (with wrap) from ptr.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx[IDW-1:0]]) begin
        grant[idx[IDW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin issue/return scheduler sharing one pipelined FP32 multiplier
// among N requesters, with owner tracking, hold/drain control and issue count.
module fp_mult_arbiter
  import fp_mult_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned LAT = 3,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  input  logic              hold,
  output logic              mul_in_valid,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_z,
  input  logic [FLG_W-1:0]  mul_flags,
  output logic [N-1:0]      resp_valid,
  output logic [31:0]       resp_z,
  output logic [FLG_W-1:0]  resp_flags,
  output logic              busy,
  output logic [31:0]       issued_cnt
);

  localparam int unsigned CW = $clog2(LAT + 2);

  fsm_t           state;
  logic [IDW-1:0] rr_ptr;
  logic [N-1:0]   grant;
  logic           grant_en;
  logic           accept;
  logic [IDW-1:0] grant_id;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic [CW-1:0]  inflight;
  tag_t           tags [0:LAT];

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Grant is suppressed during reset so req_ready reads zero while rst is high
  always_comb begin
    grant_en  = !rst && !hold && (state != DRAIN);
    req_ready = grant & {N{grant_en}};
    accept    = |(req_valid & req_ready);
    grant_id  = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_id = IDW'(i);
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k <= LAT; k++) begin
      inflight = inflight + CW'(tags[k].valid);
    end
  end

  assign busy = (inflight != '0) || (|resp_valid);

  // Control FSM together with the issue-side registers it governs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      mul_in_valid <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      issued_cnt   <= '0;
    end else begin
      mul_in_valid <= accept;
      if (accept) begin
        mul_a      <= sel_a;
        mul_b      <= sel_b;
        issued_cnt <= issued_cnt + 32'd1;
        rr_ptr     <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
      end
      unique case (state)
        IDLE: begin
          if (accept) state <= ACTIVE;
        end
        ACTIVE: begin
          if (hold && (inflight != '0))           state <= DRAIN;
          else if ((inflight == '0) && !accept)  state <= IDLE;
        end
        DRAIN: begin
          if (inflight == '0) state <= IDLE;
          else if (!hold)     state <= ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag stage LAT lines up with the multiplier output for the same operation
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k <= LAT; k++) begin
        tags[k] <= '0;
      end
      resp_valid <= '0;
      resp_z     <= '0;
      resp_flags <= '0;
    end else begin
      tags[0].valid <= accept;
      tags[0].id    <= TAG_IDW'(grant_id);
      for (int unsigned k = 1; k <= LAT; k++) begin
        tags[k] <= tags[k-1];
      end
      resp_valid <= '0;
      if (tags[LAT].valid) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (tags[LAT].id == TAG_IDW'(i)) resp_valid[i] <= 1'b1;
        end
        resp_z     <= mul_z;
        resp_flags <= mul_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed self-checking bench for fp_mult_arbiter with a LAT=3 model multiplier.
module tb_fp_mult_arbiter;
  import fp_mult_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic          hold;
  logic          mul_in_valid;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic [31:0]   mul_z;
  logic [5:0]    mul_flags;
  logic [N-1:0]  resp_valid;
  logic [31:0]   resp_z;
  logic [5:0]    resp_flags;
  logic          busy;
  logic [31:0]   issued_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mult_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .hold         (hold),
    .mul_in_valid (mul_in_valid),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_z        (mul_z),
    .mul_flags    (mul_flags),
    .resp_valid   (resp_valid),
    .resp_z       (resp_z),
    .resp_flags   (resp_flags),
    .busy         (busy),
    .issued_cnt   (issued_cnt)
  );

  function automatic logic [31:0] op_a(input int i);
    return 32'(32'h100 + i);
  endfunction

  function automatic logic [31:0] op_b(input int i);
    return 32'(32'h10000 * (i + 1));
  endfunction

  function automatic logic [31:0] model_z(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h7F800000) return 32'h7F800000;
    return a ^ b;
  endfunction

  function automatic logic [5:0] model_f(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC00000 && b == 32'h40000000) return 6'd0;
    if (a == 32'h7F800000 && b == 32'h0) return 6'(1 << FLG_INF);
    return a[5:0];
  endfunction

  // Model multiplier: three register stages from mul_in_valid to mul_z
  logic [31:0] pz [3];
  logic [5:0]  pf [3];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        pz[k] <= 32'h0;
        pf[k] <= 6'h0;
      end
    end else begin
      pz[0] <= mul_in_valid ? model_z(mul_a, mul_b) : 32'hDEAD0000;
      pf[0] <= mul_in_valid ? model_f(mul_a, mul_b) : 6'h3F;
      pz[1] <= pz[0];
      pf[1] <= pf[0];
      pz[2] <= pz[1];
      pf[2] <= pf[1];
    end
  end
  assign mul_z     = pz[2];
  assign mul_flags = pf[2];

  task automatic set_ops();
    for (int i = 0; i < int'(N); i++) begin
      req_a[32*i +: 32] = op_a(i);
      req_b[32*i +: 32] = op_b(i);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; req_valid = '1;
    set_ops();
    repeat (3) @(posedge clk);
    #2;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
    checks++; if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL reset_mul_in_valid got %b exp 0", mul_in_valid); end
    checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin errors++; $display("FAIL reset_mul_ops got %h %h exp 0 0", mul_a, mul_b); end
    checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid got %h exp 0", resp_valid); end
    checks++; if (resp_z !== 32'h0 || resp_flags !== 6'h0) begin errors++; $display("FAIL reset_resp_data got %h %h exp 0 0", resp_z, resp_flags); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (issued_cnt !== 32'h0) begin errors++; $display("FAIL reset_issued_cnt got %h exp 0", issued_cnt); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d exp 0", dut.rr_ptr); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dut.state); end
    req_valid = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy, exp_rv;
    int id;
    for (int j = 0; j < 14; j++) begin
      cyc();
      req_valid = (j < 8) ? 4'hF : 4'h0;
      #1;
      if (j < 8) begin
        exp_rdy = 4'(1 << (j % 4));
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant[%0d] got %b exp %b", j, req_ready, exp_rdy); end
      end
      exp_rv = (j >= 5 && j < 13) ? 4'(1 << ((j - 5) % 4)) : 4'h0;
      checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL fair_resp_valid[%0d] got %b exp %b", j, resp_valid, exp_rv); end
      if (exp_rv != 4'h0) begin
        id = (j - 5) % 4;
        checks++;
        if (resp_z !== model_z(op_a(id), op_b(id)) || resp_flags !== model_f(op_a(id), op_b(id))) begin
          errors++;
          $display("FAIL fair_resp_data[%0d] got %h/%h exp %h/%h", j, resp_z, resp_flags, model_z(op_a(id), op_b(id)), model_f(op_a(id), op_b(id)));
        end
      end
      checks++; if (busy !== (j >= 1 && j <= 12)) begin errors++; $display("FAIL fair_busy[%0d] got %b exp %b", j, busy, (j >= 1 && j <= 12)); end
    end
    checks++; if (issued_cnt !== 32'd8) begin errors++; $display("FAIL fair_issued_cnt got %0d exp 8", issued_cnt); end
  endtask

  task automatic test_single();
    cyc();
    req_valid = 4'b0001;
    req_a[31:0] = 32'h3FC00000;
    req_b[31:0] = 32'h40000000;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      req_valid = '0;
      #1;
      if (k == 1) begin
        checks++; if (mul_in_valid !== 1'b1) begin errors++; $display("FAIL single_mul_in_valid got %b exp 1", mul_in_valid); end
        checks++; if (mul_a !== 32'h3FC00000 || mul_b !== 32'h40000000) begin errors++; $display("FAIL single_mul_ops got %h %h exp 3fc00000 40000000", mul_a, mul_b); end
        checks++; if (issued_cnt !== 32'd9) begin errors++; $display("FAIL single_issued_cnt got %0d exp 9", issued_cnt); end
      end
      if (k == 2) begin
        checks++; if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL single_mul_in_valid_pulse got %b exp 0", mul_in_valid); end
      end
      checks++; if (resp_valid !== ((k == 5) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_resp_valid[c+%0d] got %b exp %b", k, resp_valid, (k == 5) ? 4'b0001 : 4'b0000); end
      if (k == 5) begin
        checks++; if (resp_z !== 32'h40400000 || resp_flags !== 6'h0) begin errors++; $display("FAIL single_resp_data got %h/%h exp 40400000/00", resp_z, resp_flags); end
      end
    end
    set_ops();
  endtask

  task automatic test_hold_drain();
    logic [3:0] exp_rdy, exp_rv;
    int id;
    for (int j = 0; j < 10; j++) begin
      cyc();
      req_valid = (j <= 2 || (j >= 4 && j <= 8)) ? 4'hF : 4'h0;
      hold      = (j >= 4 && j <= 8);
      #1;
      exp_rdy = (j <= 2) ? 4'(1 << (j + 1)) : 4'h0;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL hold_ready[%0d] got %b exp %b", j, req_ready, exp_rdy); end
      exp_rv = (j >= 5 && j <= 7) ? 4'(1 << (j - 4)) : 4'h0;
      checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL hold_resp_valid[%0d] got %b exp %b", j, resp_valid, exp_rv); end
      if (exp_rv != 4'h0) begin
        id = j - 4;
        checks++; if (resp_z !== model_z(op_a(id), op_b(id))) begin errors++; $display("FAIL hold_resp_z[%0d] got %h exp %h", j, resp_z, model_z(op_a(id), op_b(id))); end
      end
      if (j >= 5 && j <= 7) begin
        checks++; if (dut.state !== DRAIN) begin errors++; $display("FAIL hold_state_drain[%0d] got %0d exp DRAIN", j, dut.state); end
      end
      if (j == 8) begin
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL hold_state_idle got %0d exp IDLE", dut.state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_end got %b exp 0", busy); end
      end
      if (j == 7) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy_last got %b exp 1", busy); end
      end
    end
    hold = 1'b0;
    checks++; if (issued_cnt !== 32'd12) begin errors++; $display("FAIL hold_issued_cnt got %0d exp 12", issued_cnt); end
  endtask

  task automatic test_flag_route();
    cyc();
    req_valid = 4'b0100;
    req_a[95:64] = 32'h7F800000;
    req_b[95:64] = 32'h00000000;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL flag_ready got %b exp 0100", req_ready); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      req_valid = '0;
      #1;
      checks++; if (resp_valid !== ((k == 5) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL flag_resp_valid[c+%0d] got %b exp %b", k, resp_valid, (k == 5) ? 4'b0100 : 4'b0000); end
      if (k >= 5) begin
        checks++; if (resp_z !== 32'h7F800000 || resp_flags !== 6'b010000) begin errors++; $display("FAIL flag_resp_data[c+%0d] got %h/%b exp 7f800000/010000", k, resp_z, resp_flags); end
      end
    end
    set_ops();
  endtask

  task automatic test_reset_midflight();
    cyc();
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rstmid_ready0 got %b exp 1000", req_ready); end
    cyc();
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ready1 got %b exp 0001", req_ready); end
    cyc();
    req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (issued_cnt !== 32'h0) begin errors++; $display("FAIL rstmid_issued_cnt got %h exp 0", issued_cnt); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL rstmid_rr_ptr got %0d exp 0", dut.rr_ptr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    for (int k = 0; k < 7; k++) begin
      cyc();
      #1;
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL rstmid_resp_valid[%0d] got %b exp 0", k, resp_valid); end
    end
  endtask

  task automatic test_wrap();
    cyc();
    force dut.issued_cnt = 32'hFFFFFFFF;
    cyc();
    release dut.issued_cnt;
    cyc();
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    #1;
    checks++; if (issued_cnt !== 32'h0) begin errors++; $display("FAIL wrap_to_zero got %h exp 00000000", issued_cnt); end
    checks++; if (mul_in_valid !== 1'b1) begin errors++; $display("FAIL wrap_mul_in_valid got %b exp 1", mul_in_valid); end
    cyc();
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    #1;
    checks++; if (issued_cnt !== 32'h1) begin errors++; $display("FAIL wrap_next got %h exp 00000001", issued_cnt); end
    repeat (8) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_hold_drain();
    test_flag_route();
    test_reset_midflight();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
